// File: rtl/echo_portal_pkg.sv
// Echo portal shared definitions: method numbers, header fields,
// payload sizes and the request FSM state encoding.
package echo_portal_pkg;

  localparam logic [15:0] DEF_SAY_METHOD  = 16'd0;
  localparam logic [15:0] DEF_SAY2_METHOD = 16'd1;
  localparam int unsigned DEF_ERR_W       = 16;

  localparam int unsigned HDR_FLD_W    = 16;
  localparam int unsigned HDR_METH_LSB = 16;
  localparam int unsigned HDR_CNT_LSB  = 0;

  localparam logic [15:0] SAY_WORDS  = 16'd1;
  localparam logic [15:0] SAY2_WORDS = 16'd2;
  localparam logic [15:0] SAY_BITS   = 16'd32;
  localparam logic [15:0] SAY2_BITS  = 16'd64;

  typedef logic [1:0] req_state_t;

  localparam req_state_t ST_HDR     = 2'd0;
  localparam req_state_t ST_PAYLOAD = 2'd1;
  localparam req_state_t ST_ISSUE   = 2'd2;
  localparam req_state_t ST_DRAIN   = 2'd3;

  function automatic logic [15:0] hdr_method_of(
    input logic [31:0] w
  );
    return w[HDR_METH_LSB +: HDR_FLD_W];
  endfunction

  function automatic logic [15:0] hdr_count_of(
    input logic [31:0] w
  );
    return w[HDR_CNT_LSB +: HDR_FLD_W];
  endfunction

endpackage

// File: rtl/echo_request_input_if.sv
// Host-side request word stream with RDY/EN handshake.
interface echo_request_input_if;

  logic        RDY_requests_enq;
  logic        EN_requests_enq;
  logic [31:0] requests_enq_v;

  modport master (
    input  RDY_requests_enq,
    output EN_requests_enq,
    output requests_enq_v
  );

  modport slave (
    output RDY_requests_enq,
    input  EN_requests_enq,
    input  requests_enq_v
  );

endinterface

// File: rtl/echo_req_hdr_decode.sv
// Combinational header decode plus the per-method payload size lookup
// shared with the messageSize query.
module echo_req_hdr_decode
  import echo_portal_pkg::*;
#(
  parameter logic [15:0] SAY_METHOD  = DEF_SAY_METHOD,
  parameter logic [15:0] SAY2_METHOD = DEF_SAY2_METHOD
) (
  input  logic [31:0] hdr_word,
  input  logic [15:0] query_method,
  output logic        hdr_valid,
  output logic [15:0] hdr_method,
  output logic [15:0] hdr_count,
  output logic [15:0] query_size
);

  always_comb begin
    hdr_method = hdr_method_of(hdr_word);
    hdr_count  = hdr_count_of(hdr_word);
    hdr_valid  = 1'b0;
    unique case (1'b1)
      (hdr_method == SAY_METHOD):
        hdr_valid = (hdr_count == SAY_WORDS);
      (hdr_method == SAY2_METHOD):
        hdr_valid = (hdr_count == SAY2_WORDS);
      default:
        hdr_valid = 1'b0;
    endcase
  end

  always_comb begin
    query_size = 16'd0;
    unique case (1'b1)
      (query_method == SAY_METHOD):
        query_size = SAY_BITS;
      (query_method == SAY2_METHOD):
        query_size = SAY2_BITS;
      default:
        query_size = 16'd0;
    endcase
  end

endmodule

// File: rtl/echo_request_input.sv
// Echo portal request side: header decode, payload deserialize, core issue.
// Define ECHO_REQ_ERRCNT_EN to add the saturating bad-header counter port.
module echo_request_input
  import echo_portal_pkg::*;
#(
  parameter logic [15:0] SAY_METHOD  = DEF_SAY_METHOD,
  parameter logic [15:0] SAY2_METHOD = DEF_SAY2_METHOD
`ifdef ECHO_REQ_ERRCNT_EN
  ,
  parameter int unsigned ERR_W = DEF_ERR_W
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  echo_request_input_if.slave req,
  output logic        RDY_messageSize_size,
  input  logic [15:0] messageSize_size_methodNumber,
  output logic [15:0] messageSize_size,
  input  logic        RDY_request_say,
  output logic        EN_request_say,
  output logic [31:0] request_say_v,
  input  logic        RDY_request_say2,
  output logic        EN_request_say2,
  output logic [31:0] request_say2_a,
  output logic [31:0] request_say2_b,
  output logic        request_busy
`ifdef ECHO_REQ_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] request_err_count
`endif
);

  req_state_t  state_q, state_d;
  logic [15:0] method_q, method_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] say_v_q, say_v_d;
  logic [31:0] say2_a_q, say2_a_d;
  logic [31:0] say2_b_q, say2_b_d;

  logic        rdy;
  logic        enq_fire;
  logic        dec_valid;
  logic [15:0] dec_method;
  logic [15:0] dec_count;
  logic        is_say;
  logic        is_say2;
  logic        en_say;
  logic        en_say2;

  echo_req_hdr_decode #(
    .SAY_METHOD  (SAY_METHOD),
    .SAY2_METHOD (SAY2_METHOD)
  ) u_dec (
    .hdr_word     (req.requests_enq_v),
    .query_method (messageSize_size_methodNumber),
    .hdr_valid    (dec_valid),
    .hdr_method   (dec_method),
    .hdr_count    (dec_count),
    .query_size   (messageSize_size)
  );

  assign rdy                  = (state_q != ST_ISSUE);
  assign enq_fire             = req.EN_requests_enq & rdy;
  assign req.RDY_requests_enq = rdy;
  assign RDY_messageSize_size = 1'b1;
  assign request_busy         = (state_q != ST_HDR);

  // say wins a tie so the two EN outputs can never be high together
  assign is_say  = (method_q == SAY_METHOD);
  assign is_say2 = (method_q == SAY2_METHOD) & ~is_say;

  always_comb begin
    state_d  = state_q;
    method_d = method_q;
    count_d  = count_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    say_v_d  = say_v_q;
    say2_a_d = say2_a_q;
    say2_b_d = say2_b_q;
    en_say   = 1'b0;
    en_say2  = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        if (enq_fire) begin
          method_d = dec_method;
          count_d  = dec_count;
          idx_d    = 16'd0;
          if (dec_valid) begin
            state_d = ST_PAYLOAD;
          end else if (dec_count != 16'd0) begin
            state_d = ST_DRAIN;
            rem_d   = dec_count;
          end
        end
      end
      ST_PAYLOAD: begin
        if (enq_fire) begin
          if (is_say2) begin
            if (idx_q == 16'd0) say2_a_d = req.requests_enq_v;
            else                say2_b_d = req.requests_enq_v;
          end else begin
            say_v_d = req.requests_enq_v;
          end
          if (idx_q == count_q - 16'd1) state_d = ST_ISSUE;
          else                          idx_d   = idx_q + 16'd1;
        end
      end
      ST_ISSUE: begin
        en_say  = is_say & RDY_request_say;
        en_say2 = is_say2 & RDY_request_say2;
        if (en_say | en_say2) state_d = ST_HDR;
      end
      ST_DRAIN: begin
        if (enq_fire) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_HDR;
      method_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      say_v_q  <= '0;
      say2_a_q <= '0;
      say2_b_q <= '0;
    end else begin
      state_q  <= state_d;
      method_q <= method_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      say_v_q  <= say_v_d;
      say2_a_q <= say2_a_d;
      say2_b_q <= say2_b_d;
    end
  end

  assign EN_request_say  = en_say;
  assign EN_request_say2 = en_say2;
  assign request_say_v   = say_v_q;
  assign request_say2_a  = say2_a_q;
  assign request_say2_b  = say2_b_q;

`ifdef ECHO_REQ_ERRCNT_EN
  logic             err_evt;
  logic [ERR_W-1:0] err_q, err_d;

  assign err_evt = (state_q == ST_HDR) & enq_fire & ~dec_valid;

  always_comb begin
    err_d = err_q;
    if (err_evt && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) err_q <= '0;
    else     err_q <= err_d;
  end

  assign request_err_count = err_q;
`endif

endmodule
